// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: PC register, sequential adder and redirect mux.
// Optional redirect-target alignment check enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_INCR      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        b_taken,
    input  logic [31:0] b_pc,
    input  logic        stall,
    output logic [31:0] inst_addr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        misalign_err
);

    logic [31:0] target;

    // Carry out of bit 31 is discarded, so the PC wraps modulo 2^32.
    assign pc_plus4 = inst_addr + 32'(PC_INCR);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target = {b_pc[31:2], 2'b00};
`else
    assign target = b_pc;
`endif

    assign pc_out = b_taken ? target : pc_plus4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_addr  <= RESET_VECTOR;
            inst_valid <= 1'b0;
        end else begin
            inst_valid <= 1'b1;
            // Redirect wins over stall so a taken branch is never lost.
            if (b_taken || !stall) begin
                inst_addr <= pc_out;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= b_taken && (b_pc[1:0] != 2'b00);
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed test-plan steps followed by
// randomized traffic, checked against an arithmetic reference model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        b_taken;
    logic [31:0] b_pc;
    logic        stall;
    logic [31:0] inst_addr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_mis;

    fetch_pc_unit #(.RESET_VECTOR(RV), .PC_INCR(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .b_taken     (b_taken),
        .b_pc        (b_pc),
        .stall       (stall),
        .inst_addr   (inst_addr),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .inst_valid  (inst_valid),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return a - (a % 4);
`else
        return a;
`endif
    endfunction

    function automatic logic ref_mis(input logic bt, input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return bt && (a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, ".inst_addr"}, inst_addr, m_pc);
        chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(m_valid));
        chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(m_mis));
    endtask

    task automatic model_reset();
        m_pc    = RV;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    // Check combinational outputs, clock one edge, update the model, check registers.
    task automatic step(input string tag);
        logic [31:0] seq;
        #1;
        seq = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        chk({tag, ".pc_plus4"}, pc_plus4, seq);
        chk({tag, ".pc_out"}, pc_out, b_taken ? ref_target(b_pc) : seq);
        @(posedge clk);
        #1;
        m_mis   = ref_mis(b_taken, b_pc);
        m_valid = 1'b1;
        if (b_taken)     m_pc = ref_target(b_pc);
        else if (!stall) m_pc = seq;
        chk_regs(tag);
    endtask

    task automatic drive(input logic bt, input logic [31:0] a, input logic st);
        b_taken = bt;
        b_pc    = a;
        stall   = st;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        model_reset();
        #3;
        chk_regs("reset");
        chk("reset.pc_plus4", pc_plus4, RV + 32'd4);
        chk("reset.pc_out", pc_out, RV + 32'd4);
        repeat (2) @(posedge clk);
        #1;
        chk_regs("reset_held");
        rst = 1'b1;

        step("run1"); chk("run1.abs", inst_addr, 32'h4);
        step("run2"); chk("run2.abs", inst_addr, 32'h8);

        drive(1'b1, 32'h100, 1'b0);
        #1;
        chk("redir.pc_out_comb", pc_out, 32'h100);
        step("redir");   chk("redir.abs", inst_addr, 32'h100);
        drive(1'b0, 32'h0, 1'b0);
        step("redir+1"); chk("redir+1.abs", inst_addr, 32'h104);

        drive(1'b1, 32'h20, 1'b0); step("to20");
        drive(1'b0, 32'h0, 1'b1);
        step("stall1"); step("stall2"); chk("stall2.abs", inst_addr, 32'h20);
        drive(1'b1, 32'h40, 1'b1);
        step("stall_redir"); chk("stall_redir.abs", inst_addr, 32'h40);

        drive(1'b1, 32'hFFFF_FFFC, 1'b0); step("wrap_load");
        drive(1'b0, 32'h0, 1'b0);
        #1;
        chk("wrap.pc_plus4_abs", pc_plus4, 32'h0);
        step("wrap"); chk("wrap.abs", inst_addr, 32'h0);

        drive(1'b1, 32'h48, 1'b0); step("to48");
        drive(1'b1, 32'h200, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_regs("async_rst");
        @(posedge clk);
        #1;
        chk_regs("async_rst_edge");
        drive(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step("post_rst"); chk("post_rst.abs", inst_addr, RV + 32'd4);

        drive(1'b1, 32'h102, 1'b0); step("align");
`ifdef FETCH_ALIGN_CHECK_EN
        chk("align.abs", inst_addr, 32'h100);
        chk("align.err_abs", 32'(misalign_err), 32'h1);
`else
        chk("align.abs", inst_addr, 32'h102);
        chk("align.err_abs", 32'(misalign_err), 32'h0);
`endif
        drive(1'b0, 32'h0, 1'b0); step("align+1");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, a, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                model_reset();
                chk_regs("rand_rst");
                @(posedge clk);
                #1;
                chk_regs("rand_rst_edge");
                rst = 1'b1;
            end else begin
                step("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
